// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer
//   Command-level front end for i2c_master_oe. It takes one register command
//   (device, register pointer, read-N or write-1) and runs it on the master's
//   streams. It first writes the pointer (and the data byte for a write). For a
//   read it then issues a repeated transaction that reads N bytes, and passes
//   the bytes to a consumer stream. Each command ends with a one-cycle o_done
//   pulse and a status code on o_err.
// Ports
//   i_clk, i_rst               clock, async active-low reset
//   i_cmd_* / o_cmd_ready      command port (ready only while idle)
//   o_start                    one-cycle start pulse to the master
//   o_addr_*  / i_addr_ready   {dev, rw} stream; ready doubles as "master idle"
//   o_nbytes_* / i_nbytes_ready byte count of the current master transaction
//   o_wr_*    / i_wr_ready     write bytes (pointer, then payload)
//   i_rd_*    / o_rd_ready     read bytes from the master
//   i_nak                      master NAK level
//   o_data_*  / i_data_ready   read bytes to the consumer (1-entry skid reg)
//   o_done, o_err              end-of-command pulse; 0 ok, 1 NAK, 2 timeout
module i2c_reg_sequencer #(
    parameter int DATA_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [6:0]            i_cmd_dev,
    input  logic [DATA_DEPTH-1:0] i_cmd_reg,
    input  logic                  i_cmd_rd,
    input  logic [DATA_DEPTH-1:0] i_cmd_len,
    input  logic [DATA_DEPTH-1:0] i_cmd_wdata,
    output logic                  o_start,
    output logic [DATA_DEPTH-1:0] o_addr_bits,
    output logic                  o_addr_valid,
    input  logic                  i_addr_ready,
    output logic [DATA_DEPTH-1:0] o_nbytes_bits,
    output logic                  o_nbytes_valid,
    input  logic                  i_nbytes_ready,
    output logic [DATA_DEPTH-1:0] o_wr_bits,
    output logic                  o_wr_valid,
    input  logic                  i_wr_ready,
    input  logic [DATA_DEPTH-1:0] i_rd_bits,
    input  logic                  i_rd_valid,
    output logic                  o_rd_ready,
    input  logic                  i_nak,
    output logic [DATA_DEPTH-1:0] o_data_bits,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    output logic                  o_done,
    output logic [1:0]            o_err
);
    localparam int DW = DATA_DEPTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_W_ADDR, S_W_NB, S_W_PTR, S_W_DATA, S_W_WAIT,
        S_R_START, S_R_ADDR, S_R_NB, S_R_DATA, S_ERR, S_DONE
    } state_t;

    state_t          state, state_n;
    logic [6:0]      cmd_dev;
    logic [DW-1:0]   cmd_reg, cmd_len, cmd_wdata, rd_cnt, data_q;
    logic            cmd_rd, start_q, data_vld, timeout;
    logic [1:0]      err_q;
    logic [TW-1:0]   tcnt;

    logic cmd_acc, addr_hs, nb_hs, wr_hs, rd_hs, out_hs, any_hs, waiting, nak_live;

    assign cmd_acc  = i_cmd_valid & (state == S_IDLE);
    assign addr_hs  = o_addr_valid & i_addr_ready;
    assign nb_hs    = o_nbytes_valid & i_nbytes_ready;
    assign wr_hs    = o_wr_valid & i_wr_ready;
    assign rd_hs    = i_rd_valid & o_rd_ready;
    assign out_hs   = data_vld & i_data_ready;
    assign any_hs   = addr_hs | nb_hs | wr_hs | rd_hs | out_hs;
    // States that sit on a master/consumer handshake and therefore can time out.
    assign waiting  = !(state inside {S_IDLE, S_R_START, S_ERR, S_DONE});
    // ERR/DONE are already on the way out; a lingering NAK must not re-enter ERR.
    assign nak_live = i_nak & !(state inside {S_IDLE, S_ERR, S_DONE});

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        timeout = 1'b0;
        case (state)
            S_IDLE:    if (i_cmd_valid)    state_n = S_W_ADDR;
            S_W_ADDR:  if (i_addr_ready)   state_n = S_W_NB;
            S_W_NB:    if (i_nbytes_ready) state_n = S_W_PTR;
            S_W_PTR:   if (i_wr_ready)     state_n = cmd_rd ? S_W_WAIT : S_W_DATA;
            S_W_DATA:  if (i_wr_ready)     state_n = S_W_WAIT;
            S_W_WAIT:  if (i_addr_ready)   state_n = cmd_rd ? S_R_START : S_DONE;
            S_R_START:                     state_n = S_R_ADDR;
            S_R_ADDR:  if (i_addr_ready)   state_n = S_R_NB;
            S_R_NB:    if (i_nbytes_ready) state_n = S_R_DATA;
            S_R_DATA:  if (rd_cnt == cmd_len && !data_vld) state_n = S_DONE;
            S_ERR:                         state_n = S_DONE;
            S_DONE:                        state_n = S_IDLE;
            default:                       state_n = S_IDLE;
        endcase
        if (waiting && state_n == state && !any_hs && tcnt == T_LAST) begin
            state_n = S_DONE;
            timeout = 1'b1;
        end
        // NAK has priority over a timeout in the same cycle.
        if (nak_live) begin
            state_n = S_ERR;
            timeout = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cmd_dev   <= '0;
            cmd_reg   <= '0;
            cmd_len   <= '0;
            cmd_wdata <= '0;
            cmd_rd    <= 1'b0;
            start_q   <= 1'b0;
            err_q     <= 2'd0;
            tcnt      <= '0;
            rd_cnt    <= '0;
            data_q    <= '0;
            data_vld  <= 1'b0;
        end else begin
            start_q <= cmd_acc | (state_n == S_R_START);
            if (cmd_acc) begin
                cmd_dev   <= i_cmd_dev;
                cmd_reg   <= i_cmd_reg;
                cmd_rd    <= i_cmd_rd;
                cmd_wdata <= i_cmd_wdata;
                cmd_len   <= (i_cmd_len == '0) ? DW'(1) : i_cmd_len;
                err_q     <= 2'd0;
            end
            if (nak_live)     err_q <= 2'd1;
            else if (timeout) err_q <= 2'd2;

            if (state_n != state || any_hs) tcnt <= '0;
            else if (waiting)               tcnt <= tcnt + 1'b1;

            if (cmd_acc)    rd_cnt <= '0;
            else if (rd_hs) rd_cnt <= rd_cnt + 1'b1;

            // Skid register: a new byte may land in the same cycle the old one leaves.
            // Any abort (NAK or timeout) discards a byte still waiting for the consumer.
            if (state_n == S_ERR || state_n == S_DONE) begin
                data_vld <= 1'b0;
            end else if (rd_hs) begin
                data_q   <= i_rd_bits;
                data_vld <= 1'b1;
            end else if (out_hs) begin
                data_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        o_addr_bits   = '0;
        o_nbytes_bits = '0;
        o_wr_bits     = '0;
        case (state)
            S_W_ADDR: o_addr_bits   = DW'({cmd_dev, 1'b0});
            S_R_ADDR: o_addr_bits   = DW'({cmd_dev, 1'b1});
            S_W_NB:   o_nbytes_bits = cmd_rd ? DW'(1) : DW'(2);
            S_R_NB:   o_nbytes_bits = cmd_len;
            S_W_PTR:  o_wr_bits     = cmd_reg;
            S_W_DATA: o_wr_bits     = cmd_wdata;
            default:  ;
        endcase
    end

    assign o_cmd_ready    = (state == S_IDLE);
    assign o_start        = start_q;
    assign o_addr_valid   = (state == S_W_ADDR) | (state == S_R_ADDR);
    assign o_nbytes_valid = (state == S_W_NB)   | (state == S_R_NB);
    assign o_wr_valid     = (state == S_W_PTR)  | (state == S_W_DATA);
    assign o_rd_ready     = (state == S_R_DATA) & (~data_vld | i_data_ready);
    assign o_data_bits    = data_q;
    assign o_data_valid   = data_vld;
    assign o_done         = (state == S_DONE);
    assign o_err          = err_q;
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Randomized bench for i2c_reg_sequencer: a behavioural master/consumer
// responder with random back-pressure, and a per-command reference list of the
// transfers each stream must carry.
module tb_i2c_reg_sequencer;
    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_cmd_valid, o_cmd_ready, i_cmd_rd;
    logic [6:0] i_cmd_dev;
    logic [7:0] i_cmd_reg, i_cmd_len, i_cmd_wdata;
    logic       o_start, o_addr_valid, i_addr_ready, o_nbytes_valid, i_nbytes_ready;
    logic       o_wr_valid, i_wr_ready, i_rd_valid, o_rd_ready, i_nak;
    logic       o_data_valid, i_data_ready, o_done;
    logic [7:0] o_addr_bits, o_nbytes_bits, o_wr_bits, i_rd_bits, o_data_bits;
    logic [1:0] o_err;

    int  n_vec = 0, n_bad = 0, cyc = 0, n_start = 0;
    bq_t q_addr, q_nb, q_wr, q_out, rd_src;
    bit  m_busy, m_rw, m_have_nb, rd_taken;
    int  m_nb, m_cnt;
    bit  stall_nb, hold_wr, tog_dr, hold_dr;

    always #5 clk = ~clk;

    i2c_reg_sequencer #(.DATA_DEPTH(8), .TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_dev(i_cmd_dev), .i_cmd_reg(i_cmd_reg), .i_cmd_rd(i_cmd_rd),
        .i_cmd_len(i_cmd_len), .i_cmd_wdata(i_cmd_wdata),
        .o_start(o_start),
        .o_addr_bits(o_addr_bits), .o_addr_valid(o_addr_valid), .i_addr_ready(i_addr_ready),
        .o_nbytes_bits(o_nbytes_bits), .o_nbytes_valid(o_nbytes_valid), .i_nbytes_ready(i_nbytes_ready),
        .o_wr_bits(o_wr_bits), .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready),
        .i_rd_bits(i_rd_bits), .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready),
        .i_nak(i_nak),
        .o_data_bits(o_data_bits), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
        .o_done(o_done), .o_err(o_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input bq_t got, input bq_t exp);
        chk({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk(tag, got[i], exp[i]);
    endtask

    task automatic mst_abort();
        m_busy = 0; m_have_nb = 0; rd_taken = 0; i_rd_valid = 0;
        rd_src.delete();
    endtask

    // Master + consumer responder: drive readies at negedge, log transfers at negedge+1.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rd_taken) begin i_rd_valid = 0; rd_taken = 0; end
            i_addr_ready   = !m_busy && ($urandom_range(0, 3) != 0);
            i_nbytes_ready = !stall_nb && ($urandom_range(0, 3) != 0);
            i_wr_ready     = !hold_wr && ($urandom_range(0, 3) != 0);
            if (tog_dr)       i_data_ready = cyc[0];
            else if (hold_dr) i_data_ready = 0;
            else              i_data_ready = ($urandom_range(0, 3) != 0);
            if (!i_rd_valid && m_busy && m_rw && m_have_nb && m_cnt < m_nb &&
                $urandom_range(0, 3) != 0) begin
                i_rd_valid = 1;
                i_rd_bits  = (rd_src.size() > 0) ? rd_src[0] : 8'hEE;
            end
            #1;
            if (rst_n) begin
                if (o_start) n_start++;
                if (i_nak) m_busy = 0;
                else begin
                    if (o_addr_valid && i_addr_ready) begin
                        q_addr.push_back(o_addr_bits);
                        m_busy = 1; m_rw = o_addr_bits[0]; m_have_nb = 0; m_cnt = 0;
                    end
                    if (o_nbytes_valid && i_nbytes_ready) begin
                        q_nb.push_back(o_nbytes_bits);
                        m_nb = int'(o_nbytes_bits); m_have_nb = 1;
                    end
                    if (o_wr_valid && i_wr_ready) begin
                        q_wr.push_back(o_wr_bits);
                        m_cnt++;
                        if (m_cnt >= m_nb) m_busy = 0;
                    end
                    if (i_rd_valid && o_rd_ready) begin
                        if (rd_src.size() > 0) void'(rd_src.pop_front());
                        m_cnt++; rd_taken = 1;
                        if (m_cnt >= m_nb) m_busy = 0;
                    end
                end
                if (o_data_valid && i_data_ready) q_out.push_back(o_data_bits);
            end
        end
    end

    task automatic clear_logs();
        q_addr.delete(); q_nb.delete(); q_wr.delete(); q_out.delete();
        n_start = 0;
    endtask

    task automatic issue_cmd(input logic [6:0] dev, input logic [7:0] rg, input logic rd,
                             input logic [7:0] len, input logic [7:0] wd);
        @(negedge clk);
        i_cmd_dev = dev; i_cmd_reg = rg; i_cmd_rd = rd; i_cmd_len = len; i_cmd_wdata = wd;
        i_cmd_valid = 1;
        chk("cmd_ready_idle", o_cmd_ready, 1);
        @(negedge clk);
        i_cmd_valid = 0;
        chk("start_after_accept", o_start, 1);
        chk("cmd_ready_busy", o_cmd_ready, 0);
    endtask

    task automatic wait_done(input int budget, output int err, output int k);
        k = 0;
        while (!o_done && k < budget) begin @(negedge clk); k++; end
        chk("done_seen", o_done, 1);
        err = int'(o_err);
        @(negedge clk);
        chk("done_one_cycle", o_done, 0);
        chk("ready_after_done", o_cmd_ready, 1);
    endtask

    // Reference: pointer write transaction, then (read) a read of len bytes.
    task automatic run_cmd(input logic [6:0] dev, input logic [7:0] rg, input logic rd,
                           input logic [7:0] len, input logic [7:0] wd, input bq_t fixed);
        bq_t ea, en, ew, eo;
        int ln, e, k;
        logic [7:0] b;
        ln = (len == 0) ? 1 : int'(len);
        clear_logs();
        rd_src.delete();
        if (rd) for (int i = 0; i < ln; i++) begin
            b = (i < fixed.size()) ? fixed[i] : 8'($urandom);
            rd_src.push_back(b); eo.push_back(b);
        end
        ea.push_back({dev, 1'b0});
        en.push_back(rd ? 8'd1 : 8'd2);
        ew.push_back(rg);
        if (rd) begin
            ea.push_back({dev, 1'b1});
            en.push_back(8'(ln));
        end else ew.push_back(wd);
        issue_cmd(dev, rg, rd, len, wd);
        wait_done(3000, e, k);
        chk("err_ok", e, 0);
        chk("start_count", n_start, rd ? 2 : 1);
        cmp_q("addr", q_addr, ea);
        cmp_q("nbytes", q_nb, en);
        cmp_q("wr", q_wr, ew);
        cmp_q("data_out", q_out, eo);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bq_t none, fx;
        int e, k;
        logic [6:0] rdev;
        rst_n = 0; i_cmd_valid = 0; i_cmd_dev = 0; i_cmd_reg = 0; i_cmd_rd = 0;
        i_cmd_len = 0; i_cmd_wdata = 0; i_nak = 0; i_rd_valid = 0; i_rd_bits = 0;
        i_addr_ready = 0; i_nbytes_ready = 0; i_wr_ready = 0; i_data_ready = 0;
        stall_nb = 0; hold_wr = 0; tog_dr = 0; hold_dr = 0;
        mst_abort();
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {o_start, o_addr_valid, o_nbytes_valid, o_wr_valid, o_rd_ready,
                         o_data_valid, o_done, o_err}, 0);
        chk("rst_bus", {o_addr_bits, o_nbytes_bits, o_wr_bits, o_data_bits}, 0);
        chk("rst_cmd_ready", o_cmd_ready, 1);
        @(negedge clk); rst_n = 1;

        fx.push_back(8'hA1); fx.push_back(8'hB2); fx.push_back(8'hC3);
        run_cmd(7'h48, 8'h0F, 1, 8'd3, 8'h00, fx);
        run_cmd(7'h1D, 8'h20, 0, 8'd0, 8'h57, none);
        run_cmd(7'h11, 8'h05, 1, 8'd0, 8'h00, none);   // len 0 reads one byte
        tog_dr = 1;
        run_cmd(7'h2A, 8'h33, 1, 8'd4, 8'h00, none);
        tog_dr = 0;
        run_cmd(7'h7F, 8'hFF, 1, 8'd255, 8'h00, none);

        // NAK while the pointer byte is offered
        hold_wr = 1; clear_logs();
        issue_cmd(7'h33, 8'h44, 1, 8'd2, 8'h00);
        k = 0;
        while (!o_wr_valid && k < 40) begin @(negedge clk); k++; end
        chk("nak_ptr_valid", o_wr_valid, 1);
        chk("nak_ptr_bits", o_wr_bits, 8'h44);
        i_nak = 1;
        @(negedge clk);
        i_nak = 0;
        chk("nak_valids_drop", {o_addr_valid, o_nbytes_valid, o_wr_valid, o_rd_ready}, 0);
        wait_done(20, e, k);
        chk("nak_err", e, 1);
        chk("nak_no_read_start", n_start, 1);
        chk("nak_addr_count", q_addr.size(), 1);
        hold_wr = 0; #2 mst_abort();

        // Timeout with nbytes stream stalled
        stall_nb = 1; clear_logs();
        issue_cmd(7'h1D, 8'h20, 0, 8'd0, 8'h57);
        k = 0;
        while (!o_nbytes_valid && k < 40) begin @(negedge clk); k++; end
        chk("tmo_nb_valid", o_nbytes_valid, 1);
        chk("tmo_nb_bits", o_nbytes_bits, 8'd2);
        wait_done(40, e, k);
        chk("tmo_err", e, 2);
        chk("tmo_cycles", k, 16);
        stall_nb = 0; #2 mst_abort();

        // Async reset in the middle of the read data phase
        hold_dr = 1; clear_logs(); rd_src.delete();
        for (int i = 0; i < 5; i++) rd_src.push_back(8'h5A + 8'(i));
        issue_cmd(7'h48, 8'h01, 1, 8'd5, 8'h00);
        k = 0;
        while (!o_data_valid && k < 60) begin @(negedge clk); k++; end
        chk("rdata_reached", o_data_valid, 1);
        rst_n = 0;
        #1;
        chk("midrst_ctrl", {o_start, o_addr_valid, o_nbytes_valid, o_wr_valid, o_rd_ready,
                            o_data_valid, o_done, o_err}, 0);
        chk("midrst_bus", {o_addr_bits, o_nbytes_bits, o_wr_bits, o_data_bits}, 0);
        chk("midrst_cmd_ready", o_cmd_ready, 1);
        @(negedge clk);
        chk("midrst_no_done", o_done, 0);
        rst_n = 1; hold_dr = 0; #2 mst_abort();
        run_cmd(7'h48, 8'h0F, 1, 8'd2, 8'h00, none);

        for (int t = 0; t < 20; t++) begin
            rdev = 7'($urandom);
            run_cmd(rdev, 8'($urandom), 1'($urandom), 8'($urandom_range(0, 12)), 8'($urandom), none);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
